// File: rtl/vmem_burst_completer.sv
// +--------------------------------------------------------------------------+
// | vmem_burst_completer                                                     |
// | Burst completer: fixed/unit/strided read and write bursts against an     |
// | internal word array; reads return through a latency pipe into a          |
// | credit-protected response FIFO. Optional macro: VMEM_STALL_INJECT_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vmem_burst_completer #(
    parameter int ADDR_RANGE   = 32768,
    parameter int LENGTH_RANGE = 32,
    parameter int BUS_WIDTH    = 32,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_wr,
    input  logic [1:0]                      req_mode,
    input  logic [$clog2(ADDR_RANGE)-1:0]   req_addr,
    input  logic [$clog2(ADDR_RANGE)-1:0]   req_stride,
    input  logic [$clog2(LENGTH_RANGE):0]   req_length,
    input  logic                            wrvalid,
    input  logic [BUS_WIDTH-1:0]            wrdata,
    output logic                            wrready,
    output logic                            rddatavalid,
    output logic [BUS_WIDTH-1:0]            rddata,
    input  logic                            rddataready,
    output logic                            busy
);

    localparam int c_aw = $clog2(ADDR_RANGE);
    localparam int c_lw = $clog2(LENGTH_RANGE) + 1;
    localparam int c_cw = $clog2(RESP_DEPTH + 1);
    localparam int c_iw = $clog2(READ_LATENCY + 1);
    localparam int c_pw = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_write = 2'd1;
    localparam logic [1:0] c_read  = 2'd2;
    localparam logic [1:0] c_drain = 2'd3;

    logic [1:0]           r_state;
    logic [c_aw-1:0]      r_addr;
    logic [c_aw-1:0]      r_step;
    logic [c_lw-1:0]      r_length;
    logic [c_lw-1:0]      r_beat;
    logic [c_cw-1:0]      r_count;
    logic [c_iw-1:0]      r_inflight;
    logic [c_pw-1:0]      r_wptr;
    logic [c_pw-1:0]      r_rptr;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [BUS_WIDTH-1:0] r_pipe_dat [READ_LATENCY];
    logic [BUS_WIDTH-1:0] r_fifo     [RESP_DEPTH];
    logic [BUS_WIDTH-1:0] r_mem      [ADDR_RANGE];

    logic            w_stall;
    logic            w_empty;
    logic            w_pipe_empty;
    logic            w_accept;
    logic            w_last;
    logic            w_wr_fire;
    logic            w_credit;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [c_aw-1:0] w_step;

`ifdef VMEM_STALL_INJECT_EN
    logic [15:0] r_lfsr;

    // x^16+x^14+x^13+x^11+1, right-shifting form
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign w_empty      = (r_count == '0);
    assign w_pipe_empty = (r_inflight == '0);
    assign req_ready    = (r_state == c_idle) && w_empty && w_pipe_empty;
    assign w_accept     = req_valid && req_ready;
    assign w_last       = (r_beat == r_length - 1'b1);
    assign wrready      = (r_state == c_write) && !w_stall;
    assign w_wr_fire    = wrvalid && wrready;
    // Credit counts data already committed to arrive, so the FIFO cannot overflow.
    assign w_credit     = (int'(r_count) + int'(r_inflight)) < RESP_DEPTH;
    assign w_issue      = (r_state == c_read) && w_credit && !w_stall;
    assign w_push       = r_pipe_vld[READ_LATENCY-1];
    assign w_pop        = !w_empty && rddataready;
    assign rddatavalid  = !w_empty;
    assign rddata       = w_empty ? '0 : r_fifo[r_rptr];
    assign busy         = (r_state != c_idle) || !w_empty || !w_pipe_empty;

    always_comb begin
        case (req_mode)
            2'd1:    w_step = c_aw'(1);
            2'd2:    w_step = req_stride;
            default: w_step = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_addr   <= '0;
            r_step   <= '0;
            r_length <= '0;
            r_beat   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_step   <= w_step;
                        r_length <= req_length;
                        r_beat   <= '0;
                        if (req_length != '0) begin
                            r_state <= req_wr ? c_write : c_read;
                        end
                    end
                end
                c_write: begin
                    if (w_wr_fire) begin
                        r_addr <= r_addr + r_step;
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_state <= c_idle;
                        end
                    end
                end
                c_read: begin
                    if (w_issue) begin
                        r_addr <= r_addr + r_step;
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_state <= c_drain;
                        end
                    end
                end
                c_drain: begin
                    if (w_pipe_empty) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
            r_pipe_vld[0] <= w_issue;

            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_push) begin
                r_wptr <= (r_wptr == c_pw'(RESP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_pw'(RESP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
        end
    end

    // Storage paths carry no reset; their enables come from reset registers.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_addr] <= wrdata;
        end
        r_pipe_dat[0] <= r_mem[r_addr];
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_dat[i] <= r_pipe_dat[i-1];
        end
        if (w_push) begin
            r_fifo[r_wptr] <= r_pipe_dat[READ_LATENCY-1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vmem_burst_completer.sv
// +--------------------------------------------------------------------------+
// | tb_vmem_burst_completer                                                  |
// | Self-checking bench for vmem_burst_completer with a word-array model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vmem_burst_completer;

    localparam int AR = 32768;
    localparam int LR = 32;
    localparam int BW = 32;
    localparam int RL = 2;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [1:0]    req_mode;
    logic [14:0]   req_addr;
    logic [14:0]   req_stride;
    logic [5:0]    req_length;
    logic          wrvalid;
    logic [BW-1:0] wrdata;
    logic          wrready;
    logic          rddatavalid;
    logic [BW-1:0] rddata;
    logic          rddataready;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [int];
    logic [31:0] wbuf [32];
    logic [31:0] rq [$];
    logic [31:0] ex [$];
    int rdy_pct   = 100;
    int stall_cyc = 0;
    int rst_after = -1;
    int first_cyc, last_cyc, wr_iters;
    logic snap_rv, snap_busy, snap_rr;

    vmem_burst_completer #(
        .ADDR_RANGE  (AR),
        .LENGTH_RANGE(LR),
        .BUS_WIDTH   (BW),
        .READ_LATENCY(RL),
        .RESP_DEPTH  (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_stride (req_stride),
        .req_length (req_length),
        .wrvalid    (wrvalid),
        .wrdata     (wrdata),
        .wrready    (wrready),
        .rddatavalid(rddatavalid),
        .rddata     (rddata),
        .rddataready(rddataready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int step_of(input logic [1:0] m, input int s);
        return (m == 2'd1) ? 1 : (m == 2'd2) ? s : 0;
    endfunction

    // Expected read beats straight from the model word array.
    function automatic void expect_beats(input logic [1:0] m, input int addr, input int s, input int len);
        ex.delete();
        for (int i = 0; i < len; i++) begin
            ex.push_back(mdl[(addr + i * step_of(m, s)) & (AR - 1)]);
        end
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        wrvalid = 1'b0;
        rddataready = 1'b0;
        #1;
        snap_rv   = rddatavalid;
        snap_busy = busy;
        snap_rr   = req_ready;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_burst(input bit wr, input logic [1:0] mode, input int addr, input int stride, input int len);
        int k, guard, cyc, st;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL req_accept_timeout: req_ready=%0b required 1", req_ready);
        end
        st = step_of(mode, stride);
        req_valid = 1'b1; req_wr = wr; req_mode = mode;
        req_addr = 15'(addr); req_stride = 15'(stride); req_length = 6'(len);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1; k = 0; guard = 0;
        rq.delete(); first_cyc = -1; last_cyc = -1; wr_iters = 0;
        if (wr) begin
            while (k < len && guard < 500) begin
                if (k == rst_after) begin
                    pulse_reset();
                    break;
                end
                wrvalid = 1'b1;
                wrdata  = wbuf[k];
                if (wrready) begin
                    mdl[(addr + k * st) & (AR - 1)] = wbuf[k];
                    k++;
                end
                wr_iters++; guard++;
                @(negedge clk);
                cyc++;
            end
            wrvalid = 1'b0;
        end else begin
            while (k < len && guard < 2000) begin
                if (k == rst_after) begin
                    pulse_reset();
                    break;
                end
                rddataready = (cyc > stall_cyc) && ($urandom_range(99) < rdy_pct);
                if (cyc == stall_cyc) begin
                    snap_rv = rddatavalid;
                    snap_busy = busy;
                end
                if (rddatavalid && rddataready) begin
                    rq.push_back(rddata);
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    k++;
                end
                guard++;
                @(negedge clk);
                cyc++;
            end
            rddataready = 1'b0;
        end
        if (k < len && rst_after < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL burst_timeout: beats=%0d required %0d", k, len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 0; req_wr = 0; req_mode = 0; req_addr = 0; req_stride = 0;
        req_length = 0; wrvalid = 0; wrdata = 0; rddataready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        n_cmp++; if (wrready !== 1'b0)     begin n_bad++; $display("FAIL reset_wrready: got %b required 0", wrready); end
        n_cmp++; if (rddatavalid !== 1'b0) begin n_bad++; $display("FAIL reset_rddatavalid: got %b required 0", rddatavalid); end
        n_cmp++; if (rddata !== '0)        begin n_bad++; $display("FAIL reset_rddata: got %h required 0", rddata); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_prefill();
        for (int b = 0; b < 4; b++) begin
            foreach (wbuf[i]) wbuf[i] = $urandom;
            run_burst(1'b1, 2'd1, b * 32, 0, 32);
            n_cmp++; if (wr_iters != 32) begin n_bad++; $display("FAIL prefill_write_cycles: got %0d required 32", wr_iters); end
        end
        run_burst(1'b0, 2'd1, 0, 0, 32);
        expect_beats(2'd1, 0, 0, 32);
        n_cmp++; if (rq.size() != 32) begin n_bad++; $display("FAIL prefill_read_count: got %0d required 32", rq.size()); end
        foreach (ex[i]) begin
            n_cmp++;
            if (i >= rq.size() || rq[i] !== ex[i]) begin n_bad++; $display("FAIL prefill_read beat%0d: got %h required %h", i, rq[i], ex[i]); end
        end
    endtask

    task automatic test_unit_write_read();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        run_burst(1'b1, 2'd1, 'h10, 0, 4);
        n_cmp++; if (wr_iters != 4)     begin n_bad++; $display("FAIL unit_write_cycles: got %0d required 4", wr_iters); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL unit_write_req_ready: got %b required 1", req_ready); end
        run_burst(1'b0, 2'd1, 'h10, 0, 4);
        n_cmp++; if (first_cyc != RL + 2) begin n_bad++; $display("FAIL read_latency: got %0d required %0d", first_cyc, RL + 2); end
        n_cmp++; if (last_cyc - first_cyc != 3) begin n_bad++; $display("FAIL read_back_to_back: got span %0d required 3", last_cyc - first_cyc); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= rq.size() || rq[i] !== 32'hA0 + i) begin n_bad++; $display("FAIL unit_read beat%0d: got %h required %h", i, rq[i], 32'hA0 + i); end
        end
    endtask

    task automatic test_stride_wrap();
        foreach (wbuf[i]) wbuf[i] = $urandom;
        run_burst(1'b1, 2'd1, 'h7FFE, 0, 4);
        run_burst(1'b0, 2'd2, 'h7FFE, 3, 3);
        expect_beats(2'd2, 'h7FFE, 3, 3);
        foreach (ex[i]) begin
            n_cmp++;
            if (i >= rq.size() || rq[i] !== ex[i]) begin n_bad++; $display("FAIL stride_wrap beat%0d: got %h required %h", i, rq[i], ex[i]); end
        end
    endtask

    task automatic test_backpressure();
        foreach (wbuf[i]) wbuf[i] = $urandom;
        run_burst(1'b1, 2'd1, 'h100, 0, 8);
        stall_cyc = 20;
        run_burst(1'b0, 2'd1, 'h100, 0, 8);
        stall_cyc = 0;
        n_cmp++; if (snap_rv !== 1'b1)   begin n_bad++; $display("FAIL bp_valid_held: got %b required 1", snap_rv); end
        n_cmp++; if (snap_busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b required 1", snap_busy); end
        n_cmp++; if (first_cyc != 21)    begin n_bad++; $display("FAIL bp_first_pop: got %0d required 21", first_cyc); end
        expect_beats(2'd1, 'h100, 0, 8);
        foreach (ex[i]) begin
            n_cmp++;
            if (i >= rq.size() || rq[i] !== ex[i]) begin n_bad++; $display("FAIL bp_read beat%0d: got %h required %h", i, rq[i], ex[i]); end
        end
    endtask

    task automatic test_fixed_and_zero();
        wbuf[0] = 1; wbuf[1] = 2; wbuf[2] = 3;
        run_burst(1'b1, 2'd0, 'h5, 0, 3);
        run_burst(1'b0, 2'd1, 'h5, 0, 1);
        n_cmp++; if (rq.size() != 1 || rq[0] !== 32'd3) begin n_bad++; $display("FAIL fixed_write_word5: got %h required 3", rq[0]); end
        run_burst(1'b0, 2'd1, 'h40, 0, 0);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL zero_len_req_ready: got %b required 1", req_ready); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL zero_len_busy: got %b required 0", busy); end
        run_burst(1'b1, 2'd1, 'h40, 0, 0);
        n_cmp++; if (wrready !== 1'b0)   begin n_bad++; $display("FAIL zero_len_wrready: got %b required 0", wrready); end
    endtask

    task automatic test_reset_mid();
        rst_after = 2;
        run_burst(1'b0, 2'd1, 'h10, 0, 4);
        n_cmp++; if (snap_rv !== 1'b0)   begin n_bad++; $display("FAIL rst_rddatavalid: got %b required 0", snap_rv); end
        n_cmp++; if (snap_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", snap_busy); end
        n_cmp++; if (snap_rr !== 1'b1)   begin n_bad++; $display("FAIL rst_req_ready: got %b required 1", snap_rr); end
        n_cmp++; if (req_ready !== 1'b1 || rddatavalid !== 1'b0) begin
            n_bad++; $display("FAIL rst_release: req_ready=%b rddatavalid=%b required 1/0", req_ready, rddatavalid);
        end
        foreach (wbuf[i]) wbuf[i] = $urandom;
        run_burst(1'b1, 2'd1, 'h20, 0, 4);
        rst_after = -1;
        run_burst(1'b0, 2'd1, 'h20, 0, 4);
        expect_beats(2'd1, 'h20, 0, 4);
        foreach (ex[i]) begin
            n_cmp++;
            if (i >= rq.size() || rq[i] !== ex[i]) begin n_bad++; $display("FAIL rst_write_abandon beat%0d: got %h required %h", i, rq[i], ex[i]); end
        end
    endtask

    task automatic test_random();
        int len, addr, stride;
        logic [1:0] mode;
        bit wr;
        for (int n = 0; n < 24; n++) begin
            wr     = 1'($urandom_range(1));
            mode   = 2'($urandom_range(3));
            addr   = $urandom_range(63);
            stride = $urandom_range(7);
            len    = $urandom_range(8);
            rdy_pct = $urandom_range(100, 30);
            foreach (wbuf[i]) wbuf[i] = $urandom;
            run_burst(wr, mode, addr, stride, len);
            if (!wr) begin
                expect_beats(mode, addr, stride, len);
                foreach (ex[i]) begin
                    n_cmp++;
                    if (i >= rq.size() || rq[i] !== ex[i]) begin n_bad++; $display("FAIL random_read n%0d beat%0d: got %h required %h", n, i, rq[i], ex[i]); end
                end
            end
        end
        rdy_pct = 100;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_prefill();
        test_unit_write_read();
        test_stride_wrap();
        test_backpressure();
        test_fixed_and_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vmem_burst_completer.md
Name: vmem_burst_completer

Overview:
- Memory-side completer for the vector memory interface. Accepts one burst request at a time (read or write; fixed, unit-stride or strided addressing) and executes it beat-by-beat against an internal word array.
- Read data passes through a parametrised-latency pipeline into a credit-protected response FIFO, so the requestor can backpressure freely without losing data.
- Sits between the vector requestor and backing memory; replaces the single-mode, single-latency completer.

Parameters:
- ADDR_RANGE, 32768, number of BUS_WIDTH words in the array; must be a power of 2.
- LENGTH_RANGE, 32, maximum beats per burst.
- BUS_WIDTH, 32, data width per beat.
- READ_LATENCY, 2, cycles from read issue to data entering the FIFO; legal range 1..8.
- RESP_DEPTH, 4, response FIFO entries; must be ≥ READ_LATENCY.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  burst request valid
- req_ready  out  1  completer can accept a burst
- req_wr  in  1  1=write burst, 0=read burst
- req_mode  in  2  0=fixed addr, 1=unit stride, 2=strided, 3=reserved (treated as 0)
- req_addr  in  $clog2(ADDR_RANGE)  base word address
- req_stride  in  $clog2(ADDR_RANGE)  word stride; used in mode 2 only
- req_length  in  $clog2(LENGTH_RANGE)+1  beat count, 0..LENGTH_RANGE
- wrvalid  in  1  write beat valid
- wrdata  in  BUS_WIDTH  write beat data
- wrready  out  1  write beat accepted when wrvalid&wrready
- rddatavalid  out  1  read beat valid
- rddata  out  BUS_WIDTH  read beat data
- rddataready  in  1  requestor accepts read beat
- busy  out  1  burst active or read data still in flight/FIFO

Behaviour:
- States: IDLE, WRITE, READ, DRAIN. Reset → IDLE. Reset values: req_ready=1, wrready=0, rddatavalid=0, rddata=0, busy=0; all counters and FIFO pointers=0. Array contents are not reset.
- IDLE:
  - req_ready=1. On req_valid, latch wr/mode/addr/stride/length and clear beat counter.
  - length=0: burst completes without leaving IDLE; no beats, no memory access.
  - Otherwise go to WRITE or READ.
- Beat address = base + beat×step, truncated to $clog2(ADDR_RANGE) bits (wraps). step is 0, 1 or stride for modes 0/1/2. Beat index runs 0..length-1.
- WRITE:
  - wrready=1. Each wrvalid&wrready writes wrdata at the beat address in the same cycle and increments the beat counter.
  - Last beat (beat=length-1) → IDLE next cycle. req_ready=0 throughout.
- READ:
  - Issue one beat per cycle when credit is available. Credit = RESP_DEPTH − (FIFO occupancy + beats in flight).
  - Data enters the FIFO exactly READ_LATENCY cycles after issue.
  - After the last issue → DRAIN.
- DRAIN: no issue. → IDLE when the pipeline is empty; FIFO may still hold data.
- A new burst is accepted only when the state is IDLE and the FIFO plus pipeline are empty, so reads always precede any later write.
- rddatavalid=FIFO non-empty; rddata=FIFO head. Pop on rddatavalid&rddataready. FIFO never overflows: credit accounting is mandatory.
- Simultaneous FIFO push and pop in one cycle: occupancy unchanged.
- busy = state≠IDLE | FIFO non-empty | pipeline non-empty.
- Mid-operation reset: burst is abandoned, FIFO and pipeline are flushed, no further array writes occur. Outputs take reset values asynchronously.

Optional Feature:
- Macro VMEM_STALL_INJECT_EN.
- When defined: a 16-bit LFSR (seed 16'hACE1 at reset, polynomial x^16+x^14+x^13+x^11+1) advances every cycle. When LFSR[1:0]==0, wrready and read issue are both suppressed that cycle. Gives deterministic, reproducible backpressure for verification.
- When undefined: no stall logic; full throughput.

Test Plan:
- Write burst mode1, addr=0x10, length=4, data A0..A3 with wrvalid held high → wrready accepts 4 beats on consecutive cycles; words 0x10..0x13 hold A0..A3; req_ready returns next cycle.
- Read burst mode1, addr=0x10, length=4, rddataready=1 → first rddatavalid READ_LATENCY+1 cycles after acceptance (one accept cycle + READ_LATENCY); A0..A3 in order on consecutive cycles.
- Read burst mode2, addr=0x7FFE, stride=3, length=3 → beats read words 0x7FFE, 0x0001, 0x0004 (wrap).
- Read burst length=8, RESP_DEPTH=4, rddataready=0 for 20 cycles → exactly 4 entries buffered, issue stalls, nothing lost. Then ready=1 → all 8 beats delivered in order.
- Write burst mode0, addr=0x5, length=3, data 1,2,3 → word 0x5=3. A length=0 request → no beats, req_ready high next cycle, busy stays 0.
- Assert rst during beat 2 of a 4-beat read → rddatavalid=0 immediately, FIFO empty, state IDLE, req_ready=1 after release.
